// File: rtl/loop_seq_pkg.sv
// Shared types and width helpers for the loop_seq_pc program-address sequencer.
package loop_seq_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] start;
    logic [DEF_ADDR_W-1:0] end_a;
    logic [DEF_CNT_W-1:0]  remaining;
  } loop_entry_t;

  // Width of an occupancy count that must hold 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/loop_stack.sv
// DEPTH-entry LIFO of loop descriptors with push/pop/decrement-top/clear.
module loop_stack
  import loop_seq_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter int  CNT_W   = DEF_CNT_W,
  parameter type entry_t = loop_entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      dec_top,
  input  logic                      clear,
  input  entry_t                    push_data,
  output entry_t                    top,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int IW = idx_w(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   w_top_idx;
  logic [IW-1:0]   w_wr_idx;

  assign w_top_idx = IW'(r_cnt - CW'(1));
  assign w_wr_idx  = IW'(r_cnt);
  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign top       = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_cnt <= '0;
    else if (clear)           r_cnt <= '0;
    else if (push && !full)   r_cnt <= r_cnt + CW'(1);
    else if (pop && !empty)   r_cnt <= r_cnt - CW'(1);
  end

  // Entry storage carries no reset; only the occupancy count defines validity.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push && !full)
        r_mem[w_wr_idx] <= push_data;
      else if (dec_top && !empty)
        r_mem[w_top_idx].remaining <= r_mem[w_top_idx].remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/loop_seq_pc.sv
// Program-address sequencer with nested zero-overhead loops, jump, stall and halt.
// Optional macro LOOP_SEQ_STATS_EN adds the lp_backs loop-back counter output.
module loop_seq_pc
  import loop_seq_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                CNT_W    = DEF_CNT_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      halt,
  input  logic                      jmp_valid,
  input  logic [ADDR_W-1:0]         jmp_addr,
  input  logic                      lp_push,
  input  logic [ADDR_W-1:0]         lp_start,
  input  logic [ADDR_W-1:0]         lp_end,
  input  logic [CNT_W-1:0]          lp_count,
  output logic [ADDR_W-1:0]         pc,
  output logic                      pc_valid,
  output logic [cnt_w(DEPTH)-1:0]   lp_depth,
  output logic                      err_ovf,
  output logic                      err_nest
`ifdef LOOP_SEQ_STATS_EN
  ,
  output logic [15:0]               lp_backs
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] end_a;
    logic [CNT_W-1:0]  remaining;
  } entry_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, w_pc_nx;
  logic              r_pc_valid, w_valid_nx;
  logic              r_err_ovf, w_ovf_nx;
  logic              r_err_nest, w_nest_nx;

  logic              w_push, w_pop, w_dec, w_clear;
  logic              w_full, w_empty;
  entry_t            w_top, w_push_data;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_at_end, w_rem_gt1, w_nest_bad;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_at_end   = !w_empty && (r_pc == w_top.end_a);
  assign w_rem_gt1  = (w_top.remaining > CNT_W'(1));
  // An inner loop must end strictly before the enclosing loop's end.
  assign w_nest_bad = (lp_end < lp_start) || (!w_empty && (lp_end >= w_top.end_a));

  assign w_push_data.start     = lp_start;
  assign w_push_data.end_a     = lp_end;
  assign w_push_data.remaining = (lp_count == '0) ? CNT_W'(1) : lp_count;

  loop_stack #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .entry_t (entry_t)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .dec_top   (w_dec),
    .clear     (w_clear),
    .push_data (w_push_data),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty),
    .count     (lp_depth)
  );

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_valid_nx = r_pc_valid;
    w_ovf_nx   = r_err_ovf;
    w_nest_nx  = r_err_nest;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_dec      = 1'b0;
    w_clear    = 1'b0;
    if (en) begin
      unique case (r_state)
        BOOT: begin
          w_state_nx = RUN;
          w_valid_nx = 1'b1;
        end
        RUN: begin
          if (halt) begin
            w_state_nx = HALT;
            w_valid_nx = 1'b0;
          end else if (jmp_valid) begin
            w_pc_nx = jmp_addr;
            w_clear = 1'b1;
          end else if (lp_push) begin
            if (w_full) begin
              w_ovf_nx = 1'b1;
              w_pc_nx  = w_pc_inc;
            end else if (w_nest_bad) begin
              w_nest_nx = 1'b1;
              w_pc_nx   = w_pc_inc;
            end else begin
              w_push  = 1'b1;
              w_pc_nx = lp_start;
            end
          end else if (w_at_end) begin
            if (w_rem_gt1) begin
              w_dec   = 1'b1;
              w_pc_nx = w_top.start;
            end else begin
              w_pop   = 1'b1;
              w_pc_nx = w_top.end_a + ADDR_W'(1);
            end
          end else begin
            w_pc_nx = w_pc_inc;
          end
        end
        HALT: begin
          if (jmp_valid) begin
            w_state_nx = RUN;
            w_pc_nx    = jmp_addr;
            w_valid_nx = 1'b1;
            w_clear    = 1'b1;
          end
        end
        default: w_state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_nest <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_pc_valid <= w_valid_nx;
      r_err_ovf  <= w_ovf_nx;
      r_err_nest <= w_nest_nx;
    end
  end

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;
  assign err_ovf  = r_err_ovf;
  assign err_nest = r_err_nest;

`ifdef LOOP_SEQ_STATS_EN
  logic        w_back;
  logic [15:0] r_backs;

  assign w_back = en && (r_state == RUN) && !halt && !jmp_valid && !lp_push
                  && w_at_end && w_rem_gt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_backs <= '0;
    else if (w_back && r_backs != 16'hFFFF) r_backs <= r_backs + 16'd1;
  end

  assign lp_backs = r_backs;
`endif

endmodule

// File: tb/tb_loop_seq_pc.sv
// Directed self-checking bench for loop_seq_pc (default parameters: ADDR_W=5, CNT_W=8, DEPTH=4).
module tb_loop_seq_pc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       halt = 1'b0;
  logic       jmp_valid = 1'b0;
  logic [4:0] jmp_addr = '0;
  logic       lp_push = 1'b0;
  logic [4:0] lp_start = '0;
  logic [4:0] lp_end = '0;
  logic [7:0] lp_count = '0;
  logic [4:0] pc;
  logic       pc_valid;
  logic [2:0] lp_depth;
  logic       err_ovf;
  logic       err_nest;
`ifdef LOOP_SEQ_STATS_EN
  logic [15:0] lp_backs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_seq_pc dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .halt      (halt),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
    .lp_push   (lp_push),
    .lp_start  (lp_start),
    .lp_end    (lp_end),
    .lp_count  (lp_count),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .lp_depth  (lp_depth),
    .err_ovf   (err_ovf),
    .err_nest  (err_nest)
`ifdef LOOP_SEQ_STATS_EN
    ,
    .lp_backs  (lp_backs)
`endif
  );

  task automatic clear_cmd();
    halt      = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr  = '0;
    lp_push   = 1'b0;
    lp_start  = '0;
    lp_end    = '0;
    lp_count  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_cmd();
  endtask

  task automatic set_push(input logic [4:0] s, input logic [4:0] e, input logic [7:0] c);
    lp_push  = 1'b1;
    lp_start = s;
    lp_end   = e;
    lp_count = c;
  endtask

  task automatic set_jmp(input logic [4:0] a);
    jmp_valid = 1'b1;
    jmp_addr  = a;
  endtask

  task automatic do_reset();
    clear_cmd();
    en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset then one enabled edge: pc=0, pc_valid=1, RUN.
  task automatic boot();
    do_reset();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b0 || lp_depth !== 3'd0 || err_ovf !== 1'b0 || err_nest !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%0d vld=%0b depth=%0d ovf=%0b nest=%0b required 0/0/0/0/0",
               pc, pc_valid, lp_depth, err_ovf, err_nest);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== 5'(i) || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL boot_seq[%0d] pc=%0d vld=%0b required pc=%0d vld=1", i, pc, pc_valid, i);
      end
    end
  endtask

  task automatic test_single_loop();
    logic [4:0] exp_pc [10] = '{5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 5'd5, 5'd6};
    boot();
    tick();
    tick();
    set_push(5'd3, 5'd5, 8'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || lp_depth !== ((i < 9) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL single_loop[%0d] pc=%0d depth=%0d required pc=%0d depth=%0d",
                 i, pc, lp_depth, exp_pc[i], (i < 9) ? 1 : 0);
      end
    end
`ifdef LOOP_SEQ_STATS_EN
    checks++;
    if (lp_backs !== 16'd2) begin
      errors++;
      $display("FAIL stats_backs got=%0d required=2", lp_backs);
    end
`endif
  endtask

  task automatic test_nested();
    logic [1:0] sel   [21] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                               2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [4:0] exp_pc[21] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd1,
                               5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    logic [2:0] exp_d [21] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                               3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    boot();
    tick();
    for (int i = 0; i < 21; i++) begin
      if (sel[i] == 2'd1) set_push(5'd1, 5'd8, 8'd2);
      if (sel[i] == 2'd2) set_push(5'd3, 5'd4, 8'd2);
      tick();
      checks++;
      if (pc !== exp_pc[i] || lp_depth !== exp_d[i]) begin
        errors++;
        $display("FAIL nested[%0d] pc=%0d depth=%0d required pc=%0d depth=%0d",
                 i, pc, lp_depth, exp_pc[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_errors();
    boot();
    for (int i = 1; i <= 4; i++) begin
      set_push(5'(i), 5'(31 - i), 8'd5);
      tick();
    end
    checks++;
    if (pc !== 5'd4 || lp_depth !== 3'd4 || err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL stack_fill pc=%0d depth=%0d ovf=%0b required pc=4 depth=4 ovf=0", pc, lp_depth, err_ovf);
    end
    set_push(5'd5, 5'd26, 8'd5);
    tick();
    checks++;
    if (pc !== 5'd5 || lp_depth !== 3'd4 || err_ovf !== 1'b1 || err_nest !== 1'b0) begin
      errors++;
      $display("FAIL overflow pc=%0d depth=%0d ovf=%0b nest=%0b required pc=5 depth=4 ovf=1 nest=0",
               pc, lp_depth, err_ovf, err_nest);
    end
    set_jmp(5'd10);
    tick();
    set_push(5'd6, 5'd2, 8'd1);
    tick();
    checks++;
    if (pc !== 5'd11 || lp_depth !== 3'd0 || err_nest !== 1'b1) begin
      errors++;
      $display("FAIL nest_reversed pc=%0d depth=%0d nest=%0b required pc=11 depth=0 nest=1", pc, lp_depth, err_nest);
    end
    set_push(5'd12, 5'd20, 8'd2);
    tick();
    set_push(5'd13, 5'd20, 8'd1);
    tick();
    checks++;
    if (pc !== 5'd13 || lp_depth !== 3'd1) begin
      errors++;
      $display("FAIL nest_end_equal pc=%0d depth=%0d required pc=13 depth=1", pc, lp_depth);
    end
    halt = 1'b1;
    tick();
    set_jmp(5'd0);
    tick();
    tick();
    checks++;
    if (err_ovf !== 1'b1 || err_nest !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky ovf=%0b nest=%0b required 1/1", err_ovf, err_nest);
    end
    do_reset();
    checks++;
    if (err_ovf !== 1'b0 || err_nest !== 1'b0) begin
      errors++;
      $display("FAIL err_clear ovf=%0b nest=%0b required 0/0", err_ovf, err_nest);
    end
  endtask

  task automatic test_stall();
    boot();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      halt = 1'b1;
      set_jmp(5'd9);
      set_push(5'd3, 5'd4, 8'd2);
      tick();
      checks++;
      if (pc !== 5'd2 || pc_valid !== 1'b1 || lp_depth !== 3'd0) begin
        errors++;
        $display("FAIL stall[%0d] pc=%0d vld=%0b depth=%0d required pc=2 vld=1 depth=0", i, pc, pc_valid, lp_depth);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (pc !== 5'd3) begin
      errors++;
      $display("FAIL stall_resume pc=%0d required 3", pc);
    end
  endtask

  task automatic test_jump_halt();
    boot();
    set_push(5'd1, 5'd5, 8'd4);
    tick();
    tick();
    set_jmp(5'd20);
    tick();
    checks++;
    if (pc !== 5'd20 || lp_depth !== 3'd0 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL jmp_in_loop pc=%0d depth=%0d vld=%0b required pc=20 depth=0 vld=1", pc, lp_depth, pc_valid);
    end
    tick();
    halt = 1'b1;
    tick();
    checks++;
    if (pc !== 5'd21 || pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter pc=%0d vld=%0b required pc=21 vld=0", pc, pc_valid);
    end
    tick();
    set_push(5'd3, 5'd4, 8'd2);
    tick();
    checks++;
    if (pc !== 5'd21 || pc_valid !== 1'b0 || lp_depth !== 3'd0) begin
      errors++;
      $display("FAIL halt_hold pc=%0d vld=%0b depth=%0d required pc=21 vld=0 depth=0", pc, pc_valid, lp_depth);
    end
    set_jmp(5'd7);
    tick();
    checks++;
    if (pc !== 5'd7 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_exit pc=%0d vld=%0b required pc=7 vld=1", pc, pc_valid);
    end
    tick();
    checks++;
    if (pc !== 5'd8) begin
      errors++;
      $display("FAIL after_halt pc=%0d required 8", pc);
    end
  endtask

  task automatic test_wrap();
    boot();
    set_jmp(5'd30);
    tick();
    tick();
    tick();
    checks++;
    if (pc !== 5'd0) begin
      errors++;
      $display("FAIL pc_wrap pc=%0d required 0", pc);
    end
    set_jmp(5'd30);
    tick();
    set_push(5'd31, 5'd31, 8'd2);
    tick();
    tick();
    checks++;
    if (pc !== 5'd31 || lp_depth !== 3'd1) begin
      errors++;
      $display("FAIL single_addr_loop pc=%0d depth=%0d required pc=31 depth=1", pc, lp_depth);
    end
    tick();
    checks++;
    if (pc !== 5'd0 || lp_depth !== 3'd0) begin
      errors++;
      $display("FAIL end_wrap pc=%0d depth=%0d required pc=0 depth=0", pc, lp_depth);
    end
    set_push(5'd2, 5'd3, 8'd0);
    tick();
    tick();
    tick();
    checks++;
    if (pc !== 5'd4 || lp_depth !== 3'd0) begin
      errors++;
      $display("FAIL count_zero pc=%0d depth=%0d required pc=4 depth=0", pc, lp_depth);
    end
  endtask

  task automatic test_push_at_end();
    logic [4:0] exp_pc[6] = '{5'd4, 5'd5, 5'd3, 5'd4, 5'd5, 5'd6};
    logic [2:0] exp_d [6] = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    boot();
    tick();
    tick();
    set_push(5'd3, 5'd5, 8'd2);
    tick();
    tick();
    tick();
    set_push(5'd4, 5'd4, 8'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || lp_depth !== exp_d[i]) begin
        errors++;
        $display("FAIL push_at_end[%0d] pc=%0d depth=%0d required pc=%0d depth=%0d",
                 i, pc, lp_depth, exp_pc[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    boot();
    set_push(5'd1, 5'd3, 8'd3);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 5'd0 || pc_valid !== 1'b0 || lp_depth !== 3'd0) begin
      errors++;
      $display("FAIL async_reset pc=%0d vld=%0b depth=%0d required 0/0/0", pc, pc_valid, lp_depth);
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_nested();
    test_errors();
    test_stall();
    test_jump_halt();
    test_wrap();
    test_push_at_end();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
